// File: rtl/bextdep_arbiter_if.sv
// Bus bundle between the issue-side requesters, the bextdep_arbiter and the
// shared bit-extract/deposit unit.
//   req_*        : per-requester request channel (valid/ready, op select, operands)
//   resp_*       : per-requester response channel (one-hot valid, shared rd/err)
//   unit_*       : start/busy/done interface to the single multi-cycle unit
//   spurious_done: sticky flag for a done pulse that arrived outside a job
// Modports: slave = arbiter side, master = requesters/unit/testbench side.
interface bextdep_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  localparam int unsigned DW = 32;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_bdep;
  logic [DW*NREQ-1:0] req_rs1;
  logic [DW*NREQ-1:0] req_rs2;

  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [DW-1:0]      resp_rd;
  logic               resp_err;

  logic               unit_start;
  logic               unit_bdep;
  logic [DW-1:0]      unit_rs1;
  logic [DW-1:0]      unit_rs2;
  logic [DW-1:0]      unit_rd;
  logic               unit_busy;
  logic               unit_done;

  logic               spurious_done;

  modport slave (
    input  req_valid, req_bdep, req_rs1, req_rs2, resp_ready,
           unit_rd, unit_busy, unit_done,
    output req_ready, resp_valid, resp_rd, resp_err,
           unit_start, unit_bdep, unit_rs1, unit_rs2, spurious_done
  );

  modport master (
    output req_valid, req_bdep, req_rs1, req_rs2, resp_ready,
           unit_rd, unit_busy, unit_done,
    input  req_ready, resp_valid, resp_rd, resp_err,
           unit_start, unit_bdep, unit_rs1, unit_rs2, spurious_done
  );
endinterface

// File: rtl/bextdep_arbiter.sv
// Round-robin arbiter sharing one multi-cycle bext/bdep unit between NREQ
// requesters. One job in flight at a time: IDLE accepts a request, START
// pulses unit_start, WAIT collects unit_done (or aborts on the watchdog),
// RESP holds the result until the owning requester takes it.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : bextdep_arbiter_if.slave (request, response and unit channels)
// req_ready is combinational from req_valid and the state; all other
// outputs come straight from flops.
module bextdep_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  bextdep_arbiter_if.slave bus
);

  localparam int unsigned DW    = 32;
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  tag_q, tag_d;
  logic              unit_bdep_q, unit_bdep_d;
  logic [DW-1:0]     unit_rs1_q, unit_rs1_d;
  logic [DW-1:0]     unit_rs2_q, unit_rs2_d;
  logic              unit_start_q, unit_start_d;
  logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [DW-1:0]     resp_rd_q, resp_rd_d;
  logic              resp_err_q, resp_err_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic              spurious_q, spurious_d;

  logic              grant_any_c;
  logic [PTR_W-1:0]  grant_idx_c;
  logic [NREQ-1:0]   req_ready_c;
  logic              timeout_c;
  logic              unused_busy;

  // unit_busy is informational only
  assign unused_busy = bus.unit_busy;

  // Round-robin scan starting at rr_ptr, wrapping mod NREQ
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_any_c && bus.req_valid[PTR_W'((32'(rr_ptr_q) + i) % NREQ)]) begin
        grant_any_c = 1'b1;
        grant_idx_c = PTR_W'((32'(rr_ptr_q) + i) % NREQ);
      end
    end
  end

  // Grant is only offered while idle
  always_comb begin
    req_ready_c = '0;
    if (state_q == IDLE && grant_any_c) begin
      req_ready_c[grant_idx_c] = 1'b1;
    end
  end

  assign timeout_c = WD_EN && (wd_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any_c) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (bus.unit_done || timeout_c) state_d = RESP;
      RESP:    if (bus.resp_ready[tag_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    tag_d       = tag_q;
    unit_bdep_d = unit_bdep_q;
    unit_rs1_d  = unit_rs1_q;
    unit_rs2_d  = unit_rs2_q;
    wd_cnt_d    = wd_cnt_q;
    resp_rd_d   = resp_rd_q;
    resp_err_d  = resp_err_q;
    // A done pulse is only legitimate while waiting on a job
    spurious_d  = spurious_q | (bus.unit_done && (state_q != WAIT));

    case (state_q)
      IDLE: begin
        if (grant_any_c) begin
          tag_d = grant_idx_c;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx_c == PTR_W'(i)) begin
              unit_bdep_d = bus.req_bdep[i];
              unit_rs1_d  = bus.req_rs1[i*DW +: DW];
              unit_rs2_d  = bus.req_rs2[i*DW +: DW];
            end
          end
        end
      end
      START: begin
        wd_cnt_d = '0;
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + TO_W'(1);
        if (bus.unit_done) begin
          resp_rd_d  = bus.unit_rd;
          resp_err_d = 1'b0;
        end else if (timeout_c) begin
          resp_rd_d  = '0;
          resp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready[tag_q]) begin
          rr_ptr_d = (tag_q == PTR_LAST) ? '0 : tag_q + PTR_W'(1);
        end
      end
      default: ;
    endcase

    unit_start_d = (state_d == START);
    resp_valid_d = '0;
    if (state_d == RESP) begin
      resp_valid_d[tag_d] = 1'b1;
    end
  end

  // Datapath registers; reset also discards any in-flight job
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      tag_q        <= '0;
      unit_bdep_q  <= 1'b0;
      unit_rs1_q   <= '0;
      unit_rs2_q   <= '0;
      unit_start_q <= 1'b0;
      wd_cnt_q     <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      spurious_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_q        <= tag_d;
      unit_bdep_q  <= unit_bdep_d;
      unit_rs1_q   <= unit_rs1_d;
      unit_rs2_q   <= unit_rs2_d;
      unit_start_q <= unit_start_d;
      wd_cnt_q     <= wd_cnt_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      spurious_q   <= spurious_d;
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rd       = resp_rd_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.unit_start    = unit_start_q;
  assign bus.unit_bdep     = unit_bdep_q;
  assign bus.unit_rs1      = unit_rs1_q;
  assign bus.unit_rs2      = unit_rs2_q;
  assign bus.spurious_done = spurious_q;

endmodule

// File: tb/tb_bextdep_arbiter.sv
// Self-checking bench for bextdep_arbiter: a behavioural unit model answers
// unit_start after a programmable delay, a scoreboard records the expected
// response at request acceptance and checks it at the response handshake.
module tb_bextdep_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 8;

  typedef struct {
    int          tag;
    logic [31:0] rd;
    logic        err;
    logic        bdep;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bextdep_arbiter_if #(.NREQ(NREQ)) bus ();

  bextdep_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bext_f(input logic [31:0] v, input logic [31:0] m);
    logic [31:0] r = '0;
    int k = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        r[k[4:0]] = v[i];
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] bdep_f(input logic [31:0] v, input logic [31:0] m);
    logic [31:0] r = '0;
    int k = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        r[i] = v[k[4:0]];
        k++;
      end
    end
    return r;
  endfunction

  // ---------------- unit model ----------------
  int          done_dly      = 5;
  bit          silent        = 1'b0;
  int          inject_req    = 0;
  int          inject_ack    = 0;
  int          last_done_cyc = -1;
  int          um_cd         = 0;
  logic [31:0] um_res        = '0;

  initial begin
    bus.unit_done = 1'b0;
    bus.unit_rd   = '0;
    bus.unit_busy = 1'b0;
    forever begin
      @(negedge clk);
      bus.unit_done = 1'b0;
      if (um_cd > 0) begin
        um_cd--;
        if (um_cd == 0) begin
          bus.unit_done = 1'b1;
          bus.unit_rd   = um_res;
          bus.unit_busy = 1'b0;
          last_done_cyc = cyc;
        end
      end
      if (inject_ack != inject_req) begin
        inject_ack    = inject_req;
        bus.unit_done = 1'b1;
        bus.unit_rd   = 32'hDEAD_BEEF;
        last_done_cyc = cyc;
      end
      #2;
      if (reset) begin
        um_cd         = 0;
        bus.unit_busy = 1'b0;
      end else if (bus.unit_start) begin
        um_res        = bus.unit_bdep ? bdep_f(bus.unit_rs1, bus.unit_rs2)
                                      : bext_f(bus.unit_rs1, bus.unit_rs2);
        um_cd         = silent ? 0 : done_dly;
        bus.unit_busy = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  exp_t            sb[$];
  int              grant_log[$];
  int              model_rr       = 0;
  bit              outstanding    = 1'b0;
  logic [NREQ-1:0] prev_rv        = '0;
  logic [31:0]     prev_rd        = '0;
  int              n_accepts      = 0;
  int              n_starts       = 0;
  int              last_accept_cyc = -1;
  int              last_start_cyc = -1;
  int              last_hs_cyc    = -1;
  logic [31:0]     last_hs_rd     = '0;
  logic [NREQ-1:0] s_acc;
  logic [NREQ-1:0] s_exp_g;
  int              s_gi;
  exp_t            s_item;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        sb.delete();
        model_rr    = 0;
        outstanding = 1'b0;
        prev_rv     = '0;
      end else begin
        // acceptance: compare against an independent round-robin model
        s_acc = bus.req_valid & bus.req_ready;
        if (s_acc != '0) begin
          s_gi = -1;
          for (int k = 0; k < NREQ; k++) begin
            if (s_gi < 0 && bus.req_valid[(model_rr + k) % NREQ]) s_gi = (model_rr + k) % NREQ;
          end
          s_exp_g = '0;
          if (s_gi >= 0) s_exp_g[s_gi] = 1'b1;
          check("grant", 32'(s_acc), 32'(s_exp_g));
          if (s_gi < 0) s_gi = 0;
          s_item.tag  = s_gi;
          s_item.bdep = bus.req_bdep[s_gi];
          s_item.rs1  = bus.req_rs1[32*s_gi +: 32];
          s_item.rs2  = bus.req_rs2[32*s_gi +: 32];
          s_item.err  = silent;
          s_item.rd   = silent ? 32'h0 :
                        (s_item.bdep ? bdep_f(s_item.rs1, s_item.rs2) : bext_f(s_item.rs1, s_item.rs2));
          sb.push_back(s_item);
          grant_log.push_back(s_gi);
          n_accepts++;
          last_accept_cyc = cyc;
        end

        // unit start: one cycle after accept, never two jobs in flight
        if (bus.unit_start) begin
          n_starts++;
          last_start_cyc = cyc;
          check("start_lat", 32'(cyc), 32'(last_accept_cyc + 1));
          check("in_flight", 32'(outstanding), 32'd0);
          outstanding = 1'b1;
          if (sb.size() > 0) begin
            check("unit_rs1", bus.unit_rs1, sb[0].rs1);
            check("unit_rs2", bus.unit_rs2, sb[0].rs2);
            check("unit_bdep", 32'(bus.unit_bdep), 32'(sb[0].bdep));
          end
        end

        // responses
        if (bus.resp_valid != '0) begin
          if (sb.size() == 0) begin
            check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
          end else begin
            if (prev_rv == '0) begin
              s_exp_g = '0;
              s_exp_g[sb[0].tag] = 1'b1;
              check("resp_valid", 32'(bus.resp_valid), 32'(s_exp_g));
              if (sb[0].err) check("timeout_lat", 32'(cyc), 32'(last_start_cyc + TIMEOUT + 1));
              else           check("resp_lat", 32'(cyc), 32'(last_done_cyc + 1));
            end else begin
              check("rd_stable", bus.resp_rd, prev_rd);
              check("valid_stable", 32'(bus.resp_valid), 32'(prev_rv));
              check("bp_req_ready", 32'(bus.req_ready), 32'd0);
              check("bp_unit_start", 32'(bus.unit_start), 32'd0);
            end
            if ((bus.resp_valid & bus.resp_ready) != '0) begin
              check("resp_rd", bus.resp_rd, sb[0].rd);
              check("resp_err", 32'(bus.resp_err), 32'(sb[0].err));
              model_rr    = (sb[0].tag + 1) % NREQ;
              last_hs_cyc = cyc;
              last_hs_rd  = bus.resp_rd;
              outstanding = 1'b0;
              void'(sb.pop_front());
            end
          end
        end
        prev_rv = bus.resp_valid;
        prev_rd = bus.resp_rd;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_rd"},    bus.resp_rd, 32'd0);
    check({tag, "_resp_err"},   32'(bus.resp_err), 32'd0);
    check({tag, "_unit_start"}, 32'(bus.unit_start), 32'd0);
    check({tag, "_unit_bdep"},  32'(bus.unit_bdep), 32'd0);
    check({tag, "_unit_rs1"},   bus.unit_rs1, 32'd0);
    check({tag, "_unit_rs2"},   bus.unit_rs2, 32'd0);
    check({tag, "_spurious"},   32'(bus.spurious_done), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_accepts(input int target, input string tag);
    int n = 0;
    while (n_accepts < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n_accepts < target) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_resp_valid(input string tag);
    int n = 0;
    while (bus.resp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.resp_valid == '0) check(tag, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check(tag, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int base_a, base_s, base_g;

  initial begin
    bus.req_valid  = '0;
    bus.req_bdep   = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.resp_ready = '1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("rst");

    // single bext on requester 0
    bus.req_rs1[31:0] = 32'h1234_5678;
    bus.req_rs2[31:0] = 32'h0000_FF00;
    bus.req_bdep[0]   = 1'b0;
    bus.req_valid[0]  = 1'b1;
    wait_accepts(n_accepts + 1, "t1_accept_timeout");
    bus.req_valid = '0;
    drain("t1_drain_timeout");
    check("t1_rd", last_hs_rd, 32'h0000_0056);

    // both requesters held valid: alternating grants, one start per job
    do_reset();
    bus.req_rs1       = {32'hA5A5_0F0F, 32'hCAFE_F00D};
    bus.req_rs2       = {32'h0F0F_00FF, 32'hFFFF_0000};
    bus.req_bdep      = 2'b10;
    base_a = n_accepts;
    base_s = n_starts;
    base_g = grant_log.size();
    bus.req_valid = 2'b11;
    wait_accepts(base_a + 4, "t2_accept_timeout");
    bus.req_valid = '0;
    drain("t2_drain_timeout");
    check("t2_starts", 32'(n_starts - base_s), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > base_g + i) check("t2_order", 32'(grant_log[base_g + i]), 32'(i % 2));
      else                               check("t2_order_missing", 32'd0, 32'd1);
    end

    // response backpressure on requester 0 with requester 1 pending
    bus.req_rs1[31:0] = 32'h8000_0001;
    bus.req_rs2[31:0] = 32'hF000_000F;
    bus.req_bdep      = 2'b00;
    bus.resp_ready    = 2'b10;
    base_a = n_accepts;
    bus.req_valid[0]  = 1'b1;
    wait_accepts(base_a + 1, "t3_accept_timeout");
    bus.req_valid = '0;
    wait_resp_valid("t3_resp_timeout");
    bus.req_valid[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_still_valid", 32'(bus.resp_valid), 32'h1);
    bus.resp_ready = '1;
    wait_accepts(base_a + 2, "t3_reaccept_timeout");
    check("t3_reaccept", 32'(last_accept_cyc), 32'(last_hs_cyc + 1));
    bus.req_valid = '0;
    drain("t3_drain_timeout");

    // done pulse while idle
    check("t5_pre_spurious", 32'(bus.spurious_done), 32'd0);
    inject_req++;
    repeat (3) @(negedge clk);
    check("t5_spurious", 32'(bus.spurious_done), 32'd1);
    check("t5_no_resp", 32'(bus.resp_valid), 32'd0);
    repeat (5) @(negedge clk);
    check("t5_sticky", 32'(bus.spurious_done), 32'd1);
    do_reset();
    check_zero("t5_rst");

    // watchdog abort, then a late done while holding the error response
    silent         = 1'b1;
    bus.resp_ready = 2'b10;
    bus.req_rs1[31:0] = 32'h1111_2222;
    base_a = n_accepts;
    bus.req_valid[0] = 1'b1;
    wait_accepts(base_a + 1, "t4_accept_timeout");
    bus.req_valid = '0;
    wait_resp_valid("t4_resp_timeout");
    check("t4_err_flag", 32'(bus.resp_err), 32'd1);
    check("t4_pre_spurious", 32'(bus.spurious_done), 32'd0);
    repeat (2) @(negedge clk);
    inject_req++;
    repeat (3) @(negedge clk);
    check("t4_spurious", 32'(bus.spurious_done), 32'd1);
    bus.resp_ready = '1;
    drain("t4_drain_timeout");
    check("t4_rd", last_hs_rd, 32'd0);
    silent = 1'b0;

    // reset in the middle of a bdep job from requester 1
    do_reset();
    done_dly = 20;
    bus.req_bdep      = 2'b10;
    bus.req_rs1[63:32] = 32'h0000_00FF;
    bus.req_rs2[63:32] = 32'hF0F0_F0F0;
    base_a = n_accepts;
    bus.req_valid = 2'b10;
    wait_accepts(base_a + 1, "t6_accept_timeout");
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    do_reset();
    check_zero("t6_rst");
    done_dly = 5;
    base_a = n_accepts;
    bus.req_valid = 2'b11;
    wait_accepts(base_a + 1, "t6_regrant_timeout");
    bus.req_valid = '0;
    if (grant_log.size() > 0) check("t6_first_grant", 32'(grant_log[$]), 32'd0);
    drain("t6_drain_timeout");
    repeat (25) @(negedge clk);
    check("t6_no_stale_resp", 32'(bus.resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
